// File: rtl/dmem_responder_pkg.sv
// Shared defaults and flush-FSM encoding for the data-memory responder.
package dmem_responder_pkg;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_MEM_WORDS_LOG2 = 12;
  localparam int DEF_WB_DEPTH       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/dmem_responder_store_write_buffer.sv
// In-order posted-store FIFO of {word index, data} with a combinational
// youngest-match lookup that also sees the store arriving this cycle.
module store_write_buffer #(
  parameter int IDX_W  = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enq_i,
  input  logic [IDX_W-1:0]           enq_idx_i,
  input  logic [DATA_W-1:0]          enq_data_i,
  input  logic                       deq_i,
  output logic [IDX_W-1:0]           head_idx_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  input  logic [IDX_W-1:0]           lookup_idx_i,
  output logic                       hit_o,
  output logic [DATA_W-1:0]          hit_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  slot     [DEPTH];
  logic [DEPTH-1:0]  match;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq_i) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq_i) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(enq_i) - CNT_W'(deq_i);
    end
  end

  // When full, the slot being drained is the one being refilled; the head
  // is read before the edge, so the overlap is harmless.
  always_ff @(posedge clk_i) begin
    if (reset_i && enq_i) begin
      idx_mem[wr_ptr_reg]  <= enq_idx_i;
      data_mem[wr_ptr_reg] <= enq_data_i;
    end
  end

  // Entry gi is the gi-th oldest pending store.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign slot[gi]  = rd_ptr_reg + PTR_W'(gi);
      assign match[gi] = (CNT_W'(gi) < count_reg) && (idx_mem[slot[gi]] == lookup_idx_i);
    end
  endgenerate

  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit_o      = 1'b1;
        hit_data_o = data_mem[slot[k]];
      end
    end
    if (enq_i && (enq_idx_i == lookup_idx_i)) begin
      hit_o      = 1'b1;
      hit_data_o = enq_data_i;
    end
  end

  assign head_idx_o  = idx_mem[rd_ptr_reg];
  assign head_data_o = data_mem[rd_ptr_reg];
  assign count_o     = count_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: single-port word array behind a posted write buffer,
// with load forwarding, one-cycle registered reads and a flush handshake.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int MEM_WORDS_LOG2 = DEF_MEM_WORDS_LOG2,
  parameter int WB_DEPTH       = DEF_WB_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      dmem_we_i,
  input  logic [ADDR_W-1:0]         dmem_waddr_i,
  input  logic [DATA_W-1:0]         dmem_wdata_i,
  input  logic                      dmem_re_i,
  input  logic [ADDR_W-1:0]         dmem_raddr_i,
  output logic [DATA_W-1:0]         dmem_rdata_o,
  output logic                      dmem_rvalid_o,
  output logic [$clog2(WB_DEPTH):0] wb_count_o,
  output logic                      wb_full_o,
  input  logic                      flush_i,
  output logic                      flush_done_o
);

  localparam int IDX_W     = MEM_WORDS_LOG2;
  localparam int MEM_DEPTH = 1 << MEM_WORDS_LOG2;
  localparam int CNT_W     = $clog2(WB_DEPTH) + 1;

  logic [DATA_W-1:0] mem_array [MEM_DEPTH];
  logic [IDX_W-1:0]  widx, ridx, head_idx;
  logic [DATA_W-1:0] head_data, fwd_data;
  logic [CNT_W-1:0]  count;
  logic              fwd_hit, read_need, drain, grant, flushing;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;
  flush_state_e      state_reg, state_next;
  logic              unused_addr_bits;

  assign widx = dmem_waddr_i[MEM_WORDS_LOG2+1:2];
  assign ridx = dmem_raddr_i[MEM_WORDS_LOG2+1:2];
  assign unused_addr_bits = ^{dmem_waddr_i[ADDR_W-1:MEM_WORDS_LOG2+2], dmem_waddr_i[1:0],
                              dmem_raddr_i[ADDR_W-1:MEM_WORDS_LOG2+2], dmem_raddr_i[1:0]};

  store_write_buffer #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (WB_DEPTH)
  ) u_wb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enq_i        (dmem_we_i),
    .enq_idx_i    (widx),
    .enq_data_i   (dmem_wdata_i),
    .deq_i        (drain),
    .head_idx_o   (head_idx),
    .head_data_o  (head_data),
    .count_o      (count),
    .lookup_idx_i (ridx),
    .hit_o        (fwd_hit),
    .hit_data_o   (fwd_data)
  );

  // Draining at WB_DEPTH-1 keeps headroom for the unconditional enqueue.
  assign read_need = dmem_re_i && !fwd_hit;
  assign drain     = (count != '0) &&
                     (!read_need || (count >= CNT_W'(WB_DEPTH - 1)) || flushing);
  assign grant     = read_need && !drain && !flushing;

  always_ff @(posedge clk_i) begin
    if (reset_i && drain) mem_array[head_idx] <= head_data;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= (dmem_re_i && fwd_hit) || grant;
      if (dmem_re_i && fwd_hit) rdata_reg <= fwd_data;
      else if (grant)           rdata_reg <= mem_array[ridx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (flush_i) state_next = ST_FLUSH;
      ST_FLUSH: if ((count == '0) && !dmem_we_i) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flushing     = (state_reg == ST_FLUSH);
    flush_done_o = (state_reg == ST_DONE);
  end

  assign dmem_rdata_o  = rdata_reg;
  assign dmem_rvalid_o = rvalid_reg;
  assign wb_count_o    = count;
  assign wb_full_o     = (count == CNT_W'(WB_DEPTH));

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench: a queue-based reference model predicts each cycle's
// outputs, which are popped and compared after the following edge.
module tb_dmem_responder;

  localparam int WB = 4;

  typedef struct {
    bit          rst, we;
    logic [31:0] wa, wd;
    bit          re;
    logic [31:0] ra;
    bit          fl;
  } stim_t;

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    bit          rknown;
    logic [2:0]  count;
    logic        full;
    logic        done;
  } exp_t;

  typedef struct {
    logic [11:0] idx;
    logic [31:0] data;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        reset_i, dmem_we_i, dmem_re_i, flush_i;
  logic [31:0] dmem_waddr_i, dmem_wdata_i, dmem_raddr_i;
  logic [31:0] dmem_rdata_o;
  logic        dmem_rvalid_o, wb_full_o, flush_done_o;
  logic [2:0]  wb_count_o;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        sb[$];
  ent_t        mq[$];
  logic [31:0] marr [int];
  int          mstate = 0;
  logic [31:0] m_rdata = '0;
  bit          m_rknown = 1'b1;
  bit          m_rvalid = 1'b0;

  always #5 clk_i = ~clk_i;

  dmem_responder dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .dmem_we_i     (dmem_we_i),
    .dmem_waddr_i  (dmem_waddr_i),
    .dmem_wdata_i  (dmem_wdata_i),
    .dmem_re_i     (dmem_re_i),
    .dmem_raddr_i  (dmem_raddr_i),
    .dmem_rdata_o  (dmem_rdata_o),
    .dmem_rvalid_o (dmem_rvalid_o),
    .wb_count_o    (wb_count_o),
    .wb_full_o     (wb_full_o),
    .flush_i       (flush_i),
    .flush_done_o  (flush_done_o)
  );

  // Drives one cycle, advances the reference model, pushes its prediction.
  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [11:0] wi, ri;
    logic [31:0] fd;
    bit          found, hit, drain, grant;
    int          n;
    reset_i = s.rst; dmem_we_i = s.we; dmem_waddr_i = s.wa; dmem_wdata_i = s.wd;
    dmem_re_i = s.re; dmem_raddr_i = s.ra; flush_i = s.fl;
    wi = s.wa[13:2];
    ri = s.ra[13:2];
    fd = '0;
    if (!s.rst) begin
      mq.delete(); mstate = 0; m_rdata = '0; m_rknown = 1'b1; m_rvalid = 1'b0;
    end else begin
      found = 1'b0;
      if (s.we && wi == ri) begin found = 1'b1; fd = s.wd; end
      else begin
        for (int k = mq.size() - 1; k >= 0; k--)
          if (!found && mq[k].idx == ri) begin found = 1'b1; fd = mq[k].data; end
      end
      hit   = s.re && found;
      n     = mq.size();
      drain = (n > 0) && (!(s.re && !found) || n >= WB - 1 || mstate == 1);
      grant = s.re && !found && !drain && mstate != 1;
      m_rvalid = hit || grant;
      if (hit) begin m_rdata = fd; m_rknown = 1'b1; end
      else if (grant) begin
        if (marr.exists(int'(ri))) begin m_rdata = marr[int'(ri)]; m_rknown = 1'b1; end
        else m_rknown = 1'b0;
      end
      if (drain) begin marr[int'(mq[0].idx)] = mq[0].data; void'(mq.pop_front()); end
      if (s.we) mq.push_back('{idx: wi, data: s.wd});
      case (mstate)
        0: if (s.fl) mstate = 1;
        1: if (n == 0 && !s.we) mstate = 2;
        default: mstate = 0;
      endcase
    end
    e.rvalid = m_rvalid; e.rdata = m_rdata; e.rknown = m_rknown;
    e.count = 3'(mq.size()); e.full = (mq.size() == WB); e.done = (mstate == 2);
    sb.push_back(e);
    @(posedge clk_i); #1;
    cyc++;
  endtask

  function automatic stim_t st(bit rst, bit we, logic [31:0] wa, logic [31:0] wd,
                               bit re, logic [31:0] ra, bit fl);
    st = '{rst: rst, we: we, wa: wa, wd: wd, re: re, ra: ra, fl: fl};
  endfunction

  task automatic test_reset();
    stim_t q[$];
    exp_t  e;
    logic [39:0] got, want;
    q.push_back(st(0, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    q.push_back(st(0, 1, 32'h40, 32'h00000BAD, 1, 32'h40, 0));
    q.push_back(st(0, 1, 32'h44, 32'h00000BAD, 1, 32'h40, 1));
    q.push_back(st(1, 0, 0, 0, 1, 32'h40, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      cycle(q[i]);
      e = sb.pop_front();
      got  = {dmem_rvalid_o, e.rknown ? dmem_rdata_o : 32'h0, wb_count_o, wb_full_o, flush_done_o};
      want = {e.rvalid, e.rknown ? e.rdata : 32'h0, e.count, e.full, e.done};
      total++;
      if (got !== want) begin bad++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, got, want); end
      else $display("reset      cyc=%0d out=%h", cyc, got);
    end
  endtask

  task automatic test_forward();
    stim_t q[$];
    exp_t  e;
    logic [39:0] got, want;
    q.push_back(st(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h100, 0));
    q.push_back(st(1, 1, 32'h200, 32'h00001234, 1, 32'h200, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h4103, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      cycle(q[i]);
      e = sb.pop_front();
      got  = {dmem_rvalid_o, e.rknown ? dmem_rdata_o : 32'h0, wb_count_o, wb_full_o, flush_done_o};
      want = {e.rvalid, e.rknown ? e.rdata : 32'h0, e.count, e.full, e.done};
      total++;
      if (got !== want) begin bad++; $display("FAIL forward cyc=%0d got=%h want=%h", cyc, got, want); end
      else $display("forward    cyc=%0d out=%h", cyc, got);
    end
  endtask

  task automatic test_forced_drain();
    stim_t q[$];
    exp_t  e;
    logic [39:0] got, want;
    q.push_back(st(1, 1, 32'h300, 32'h1, 1, 32'h100, 0));
    q.push_back(st(1, 1, 32'h300, 32'h2, 1, 32'h100, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h300, 0));
    for (int k = 0; k < 6; k++)
      q.push_back(st(1, 1, 32'h304 + 4 * k, 32'h10 + k, 1, 32'h100, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h100, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h310, 0));
    for (int k = 0; k < 4; k++) q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      cycle(q[i]);
      e = sb.pop_front();
      got  = {dmem_rvalid_o, e.rknown ? dmem_rdata_o : 32'h0, wb_count_o, wb_full_o, flush_done_o};
      want = {e.rvalid, e.rknown ? e.rdata : 32'h0, e.count, e.full, e.done};
      total++;
      if (got !== want) begin bad++; $display("FAIL forced_drain cyc=%0d got=%h want=%h", cyc, got, want); end
      else $display("drain      cyc=%0d out=%h", cyc, got);
    end
  endtask

  task automatic test_flush(input bit mid_store);
    stim_t q[$];
    exp_t  e;
    logic [39:0] got, want;
    int pulses = 0;
    for (int k = 0; k < 3; k++) q.push_back(st(1, 1, 32'h500 + 4 * k, 32'hF00 + k, 1, 32'h100, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 1));
    q.push_back(st(1, mid_store, 32'h50C, 32'hF0F, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 1, 32'h500, 0));
    q.push_back(st(1, 0, 0, 0, 1, 32'h100, 0));
    for (int k = 0; k < 4; k++) q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) q.push_back(st(1, 0, 0, 0, 1, 32'h500 + 4 * k, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) q.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      cycle(q[i]);
      if (flush_done_o === 1'b1) pulses++;
      e = sb.pop_front();
      got  = {dmem_rvalid_o, e.rknown ? dmem_rdata_o : 32'h0, wb_count_o, wb_full_o, flush_done_o};
      want = {e.rvalid, e.rknown ? e.rdata : 32'h0, e.count, e.full, e.done};
      total++;
      if (got !== want) begin bad++; $display("FAIL flush cyc=%0d got=%h want=%h", cyc, got, want); end
      else $display("flush      cyc=%0d out=%h", cyc, got);
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL flush_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t s;
    logic [39:0] got, want;
    for (int i = 0; i < 300; i++) begin
      s = st(1, $urandom_range(0, 1), ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 14) | $urandom_range(0, 3),
             $urandom, $urandom_range(0, 9) < 6,
             ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 14) | $urandom_range(0, 3),
             $urandom_range(0, 19) == 0);
      cycle(s);
      e = sb.pop_front();
      got  = {dmem_rvalid_o, e.rknown ? dmem_rdata_o : 32'h0, wb_count_o, wb_full_o, flush_done_o};
      want = {e.rvalid, e.rknown ? e.rdata : 32'h0, e.count, e.full, e.done};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, got, want); end
      else $display("b2b        cyc=%0d out=%h", cyc, got);
    end
  endtask

  initial begin
    reset_i = 1'b0; dmem_we_i = 1'b0; dmem_re_i = 1'b0; flush_i = 1'b0;
    dmem_waddr_i = '0; dmem_wdata_i = '0; dmem_raddr_i = '0;
    @(posedge clk_i); #1;
    test_reset();
    test_forward();
    test_forced_drain();
    test_flush(1'b0);
    test_flush(1'b1);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
